shot_controller: RTL

Sequences the player's single laser shot in Space Invaders. It turns the fire button into a launch, moves the shot upward once per video frame, and retires the shot when it reaches the top limit or an invader hit is reported. It then enforces a reload cooldown. It sits between the button inputs, the ship position register and the collision/score logic, and drives the shot sprite position to the renderer.

---
 rtl/shot_controller_if.sv | 26 ++
 rtl/shot_controller.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/shot_controller_if.sv
// shot_controller_if: groups the controller's per-frame control, button,
// ship position and collision inputs with the shot sprite / scoring outputs.
// The master side (game logic / bench) drives the inputs; the slave side is
// the shot controller itself.
interface shot_controller_if;
    logic        clear;        // synchronous game restart
    logic        frame_tick;   // one-cycle pulse per video frame
    logic        fire_n;       // fire button, active-low, asynchronous
    logic [10:0] ship_x;       // ship right edge
    logic        hit;          // shot overlaps an invader (level)
    logic [10:0] shot_x;       // shot sprite X
    logic [10:0] shot_y;       // shot sprite Y
    logic        shot_active;  // shot in flight and drawn
    logic        score_inc;    // one-cycle pulse per confirmed hit
    logic        ready;        // controller idle, a shot may be launched

    modport master (
        output clear, frame_tick, fire_n, ship_x, hit,
        input  shot_x, shot_y, shot_active, score_inc, ready
    );

    modport slave (
        input  clear, frame_tick, fire_n, ship_x, hit,
        output shot_x, shot_y, shot_active, score_inc, ready
    );
endinterface

// File: rtl/shot_controller.sv
// shot_controller: sequences the player's single laser shot.
// Fire button -> synchronizer -> edge detect -> LAUNCH -> FLIGHT (rises
// SHOT_STEP per frame) -> retire on hit or top limit -> COOLDOWN of
// COOLDOWN_FRAMES frame ticks -> IDLE.
// Optional feature macro: SHOT_AUTOFIRE_EN -- when defined, a held (low)
// synced fire level launches from IDLE, so a held button auto-repeats.
module shot_controller #(
    parameter logic [10:0] SHOT_STEP       = 11'd8,
    parameter logic [10:0] TOP_Y           = 11'd55,
    parameter logic [10:0] SPAWN_Y         = 11'd470,
    parameter logic [10:0] X_OFFSET        = 11'd16,
    parameter logic [7:0]  COOLDOWN_FRAMES = 8'd15
) (
    input  logic              clk,
    input  logic              reset,
    shot_controller_if.slave  bus
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_LAUNCH   = 2'd1;
    localparam logic [1:0] ST_FLIGHT   = 2'd2;
    localparam logic [1:0] ST_COOLDOWN = 2'd3;

    logic        r_sync1;
    logic        r_sync2;
    logic        r_hist;
    logic [1:0]  r_state;
    logic [7:0]  r_cnt;
    logic [10:0] r_shot_x;
    logic [10:0] r_shot_y;
    logic        r_shot_active;
    logic        r_score_inc;

    logic        w_press;
    logic        w_launch;
    logic [11:0] w_retire_limit;
    logic        w_near_top;

    // Falling edge of the synchronized button (released -> pressed).
    assign w_press = r_hist & ~r_sync2;

`ifdef SHOT_AUTOFIRE_EN
    // A held button is enough to launch, giving auto-repeat after cooldown.
    assign w_launch = ~r_sync2;
`else
    // Only a fresh press launches; a held button fires once.
    assign w_launch = w_press;
`endif

    // Retirement threshold computed one bit wider so it can never wrap.
    assign w_retire_limit = {1'b0, TOP_Y} + {1'b0, SHOT_STEP};
    assign w_near_top     = ({1'b0, r_shot_y} < w_retire_limit);

    // Two-flop synchronizer plus history flop for the asynchronous fire button.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_hist  <= 1'b1;
        end else if (bus.clear) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_hist  <= 1'b1;
        end else begin
            r_sync1 <= bus.fire_n;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    // Shot state machine: launch, flight, retirement and reload cooldown.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 8'd0;
            r_shot_x      <= 11'd0;
            r_shot_y      <= 11'd0;
            r_shot_active <= 1'b0;
            r_score_inc   <= 1'b0;
        end else if (bus.clear) begin
            // clear wins over a coincident hit, so no score is awarded.
            r_state       <= ST_IDLE;
            r_cnt         <= 8'd0;
            r_shot_x      <= 11'd0;
            r_shot_y      <= 11'd0;
            r_shot_active <= 1'b0;
            r_score_inc   <= 1'b0;
        end else begin
            r_score_inc <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_launch) begin
                        r_state <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    // ship_x is captured only here; the shot does not follow the ship.
                    r_shot_x      <= bus.ship_x - X_OFFSET;
                    r_shot_y      <= SPAWN_Y;
                    r_shot_active <= 1'b1;
                    r_state       <= ST_FLIGHT;
                end
                ST_FLIGHT: begin
                    if (bus.hit) begin
                        r_shot_active <= 1'b0;
                        r_score_inc   <= 1'b1;
                        r_cnt         <= COOLDOWN_FRAMES;
                        r_state       <= ST_COOLDOWN;
                    end else if (bus.frame_tick) begin
                        if (w_near_top) begin
                            r_shot_active <= 1'b0;
                            r_cnt         <= COOLDOWN_FRAMES;
                            r_state       <= ST_COOLDOWN;
                        end else begin
                            r_shot_y <= r_shot_y - SHOT_STEP;
                        end
                    end
                end
                ST_COOLDOWN: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= ST_IDLE;
                    end else if (bus.frame_tick) begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Positions hold after retirement; the renderer gates on shot_active.
    assign bus.shot_x      = r_shot_x;
    assign bus.shot_y      = r_shot_y;
    assign bus.shot_active = r_shot_active;
    assign bus.score_inc   = r_score_inc;
    assign bus.ready       = (r_state == ST_IDLE);

endmodule
